// File: rtl/paridade_pkg.sv
// Shared definitions for the serial parity checker.
//   state_t   : receiver FSM states
//   START_VAL : line level of a start bit
//   STOP_VAL  : line level of a valid stop bit
//   cnt_w()   : counter width that stays >= 1 for one-bit words
package paridade_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic START_VAL = 1'b0;
  localparam logic STOP_VAL  = 1'b1;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acumulador_paridade.sv
// One-bit running-parity register.
//   clk, reset : clock, async active-high reset
//   clr        : synchronous clear (wins over en)
//   en         : toggle q this cycle
//   q          : current parity
module acumulador_paridade (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= 1'b0;
    else if (clr) q <= 1'b0;
    else if (en)  q <= ~q;
  end

endmodule

// File: rtl/verificador_paridade_serial.sv
// Serial frame receiver with parity / stop-bit checking.
// Frame: start(0), DATA_BITS data LSB first, parity, stop(1).
//   clk, reset  : clock, async active-high reset
//   in_bit      : serial line, sampled when in_valid=1
//   in_valid    : one serial bit per strobed cycle
//   data_out    : last completed data word
//   frame_valid : one-cycle pulse per completed frame
//   parity_err  : parity mismatch on last frame
//   frame_err   : stop bit was 0 on last frame
//   busy        : receiver outside IDLE
module verificador_paridade_serial
  import paridade_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_bit,
  input  logic                 in_valid,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int            CW   = cnt_w(DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);
  localparam logic          ODD  = (ODD_PARITY != 0);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 err_pend;
  logic                 par_q, par_clr, par_en;

  // LSB-first: new bits enter at the top, so after DATA_BITS shifts the
  // first received bit sits at bit 0.
  generate
    if (DATA_BITS == 1) begin : g_sh1
      assign shreg_nxt = in_bit;
    end else begin : g_shn
      assign shreg_nxt = {in_bit, shreg[DATA_BITS-1:1]};
    end
  endgenerate

  // Parity restarts on the start bit and folds in every data '1'.
  assign par_clr = in_valid && (state == IDLE) && (in_bit == START_VAL);
  assign par_en  = in_valid && (state == DATA) && in_bit;

  acumulador_paridade u_par (
    .clk   (clk),
    .reset (reset),
    .clr   (par_clr),
    .en    (par_en),
    .q     (par_q)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      err_pend    <= 1'b0;
      data_out    <= '0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (in_valid) begin
        case (state)
          IDLE: if (in_bit == START_VAL) begin
            state <= DATA;
            cnt   <= '0;
          end
          DATA: begin
            shreg <= shreg_nxt;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= PARITY;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          PARITY: begin
            // par_q already includes the last data bit here.
            err_pend <= par_q ^ in_bit ^ ODD;
            state    <= STOP;
          end
          STOP: begin
            // Always back to IDLE; a bad stop bit is only flagged.
            data_out    <= shreg;
            parity_err  <= err_pend;
            frame_err   <= (in_bit != STOP_VAL);
            frame_valid <= 1'b1;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_verificador_paridade_serial.sv
module tb_verificador_paridade_serial;

  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          bit_a = 1'b1, vld_a = 1'b0;
  logic          bit_b = 1'b1, vld_b = 1'b0;
  logic [DB-1:0] dout_a, dout_b;
  logic          fv_a, pe_a, fe_a, busy_a;
  logic          fv_b, pe_b, fe_b, busy_b;

  always #5 clk = ~clk;

  verificador_paridade_serial #(.DATA_BITS(DB), .ODD_PARITY(0)) u_even (
    .clk(clk), .reset(reset), .in_bit(bit_a), .in_valid(vld_a),
    .data_out(dout_a), .frame_valid(fv_a), .parity_err(pe_a),
    .frame_err(fe_a), .busy(busy_a));

  verificador_paridade_serial #(.DATA_BITS(DB), .ODD_PARITY(1)) u_odd (
    .clk(clk), .reset(reset), .in_bit(bit_b), .in_valid(vld_b),
    .data_out(dout_b), .frame_valid(fv_b), .parity_err(pe_b),
    .frame_err(fe_b), .busy(busy_b));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected results of frames in flight, per receiver.
  typedef struct {
    logic [DB-1:0] data;
    logic          perr;
    logic          ferr;
  } exp_t;

  exp_t      qa[$];
  exp_t      qb[$];
  int        pulses_a = 0, pulses_b = 0;
  int        cyc = 0, last_b = 0;
  logic [DB-1:0] hold_a = '0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset) begin
      if (fv_a) begin
        if (qa.size() == 0) chk("a_spurious_pulse", fv_a, 0);
        else begin
          e = qa.pop_front();
          chk("a_data", dout_a, e.data);
          chk("a_perr", pe_a, e.perr);
          chk("a_ferr", fe_a, e.ferr);
          if (e.ferr) chk("a_idle_after_ferr", busy_a, 0);
          hold_a = e.data;
          pulses_a++;
        end
      end
      if (fv_b) begin
        if (qb.size() == 0) chk("b_spurious_pulse", fv_b, 0);
        else begin
          e = qb.pop_front();
          chk("b_data", dout_b, e.data);
          chk("b_perr", pe_b, e.perr);
          chk("b_ferr", fe_b, e.ferr);
          if (pulses_b > 0) chk("b_spacing", cyc - last_b, DB + 3);
          last_b = cyc;
          pulses_b++;
        end
      end
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic send_bit(input int d, input logic b);
    if (d == 0) begin bit_a = b; vld_a = 1'b1; end
    else        begin bit_b = b; vld_b = 1'b1; end
    @(posedge clk); #1;
    vld_a = 1'b0; vld_b = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int d, input logic [DB-1:0] data,
                            input logic pbit, input logic sbit, input int maxgap);
    exp_t e;
    logic [DB+2:0] bits;
    e.data = data;
    e.perr = (^data) ^ pbit ^ (d != 0);
    e.ferr = ~sbit;
    if (d == 0) qa.push_back(e); else qb.push_back(e);
    bits = {sbit, pbit, data, 1'b0};
    for (int i = 0; i < DB + 3; i++) begin
      send_bit(d, bits[i]);
      if (d == 0 && i == 0) chk("a_busy_after_start", busy_a, 1);
      if (d == 0 && i == DB + 1) chk("a_hold_data", dout_a, hold_a);
      if (maxgap > 0) idle_cycles($urandom_range(maxgap, 0));
    end
  endtask

  initial begin
    int p0;
    logic [DB-1:0] rd;
    logic pb;
    #3;
    chk("rst_data", dout_a, 0);
    chk("rst_fv", fv_a, 0);
    chk("rst_perr", pe_a, 0);
    chk("rst_ferr", fe_a, 0);
    chk("rst_busy", busy_a, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(2);

    // Good 0xA5, then bad parity, then bad stop followed by a good frame.
    send_frame(0, 8'hA5, 1'b0, 1'b1, 0);
    send_frame(0, 8'hA5, 1'b1, 1'b1, 0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 0);
    send_frame(0, 8'h81, 1'b0, 1'b1, 0);
    idle_cycles(2);

    // Gapped 0x5A: exactly one pulse.
    p0 = pulses_a;
    send_frame(0, 8'h5A, 1'b0, 1'b1, 3);
    idle_cycles(2);
    chk("a_gapped_one_pulse", pulses_a - p0, 1);

    // Abort after 4 data bits with reset.
    send_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_data", dout_a, 0);
    chk("mid_rst_fv", fv_a, 0);
    hold_a = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    p0 = pulses_a;
    idle_cycles(3);
    chk("no_pulse_after_abort", pulses_a - p0, 0);
    send_frame(0, 8'hFF, 1'b0, 1'b1, 0);
    idle_cycles(2);
    chk("ff_after_abort", pulses_a - p0, 1);

    // Odd parity, 0x00 twice back to back.
    send_frame(1, 8'h00, 1'b1, 1'b1, 0);
    send_frame(1, 8'h00, 1'b1, 1'b1, 0);
    idle_cycles(2);
    chk("b_pulses", pulses_b, 2);

    // Random frames with random gaps and idle line between frames.
    for (int f = 0; f < 30; f++) begin
      rd = DB'($urandom);
      pb = ($urandom_range(3, 0) == 0) ? ~(^rd) : (^rd);
      repeat ($urandom_range(2, 0)) send_bit(0, 1'b1);
      send_frame(0, rd, pb, ($urandom_range(5, 0) != 0), $urandom_range(3, 0));
    end
    idle_cycles(4);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/verificador_paridade_serial.md
VERIFICADOR_PARIDADE_SERIAL -- requirements
Module: verificador_paridade_serial

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: number of data bits per frame, legal range 1..16.
REQ-002 SHALL have parameter ODD_PARITY, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_bit, input, 1 bit: serial line, sampled only when in_valid=1.
REQ-006 SHALL have port in_valid, input, 1 bit: bit strobe; one serial bit per cycle with in_valid=1.
REQ-007 SHALL have port data_out, output, DATA_BITS bits: last received data word.
REQ-008 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when a frame completes.
REQ-009 SHALL have port parity_err, output, 1 bit: parity mismatch on the last completed frame.
REQ-010 SHALL have port frame_err, output, 1 bit: stop bit was 0 on the last completed frame.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL consume the serial stream produced by the upstream parity generator, framed as: start bit (0), then DATA_BITS data bits LSB first, then 1 parity bit, then stop bit (1).
REQ-013 SHALL implement FSM states IDLE, DATA, PARITY, STOP; all transitions occur only on cycles with in_valid=1.
REQ-014 SHALL, in IDLE, stay in IDLE on in_bit=1 and move to DATA on in_bit=0 (start bit).
REQ-015 SHALL, in DATA, shift each bit into a DATA_BITS-wide register LSB first, count bits modulo DATA_BITS, and move to PARITY after the DATA_BITS-th bit.
REQ-016 SHALL keep a running parity over the data bits: cleared at the start bit, toggled on each data bit equal to 1.
REQ-017 SHALL, in PARITY, set the pending error to (running parity XOR received parity bit XOR ODD_PARITY), then move to STOP.
REQ-018 SHALL, in STOP, always return to IDLE; stop bit=0 sets frame_err for that frame (no resynchronisation hunt).
REQ-019 SHALL register data_out, parity_err and frame_err, and pulse frame_valid for exactly one cycle, on the clock edge that samples the stop bit, so all are visible the cycle after it.
REQ-020 SHALL hold data_out, parity_err and frame_err stable until the next frame completes.
REQ-021 SHALL freeze state, counter, shift register and running parity on cycles with in_valid=0, for any number of cycles.
REQ-022 SHALL accept a new start bit on the first valid bit after the stop bit, so back-to-back frames are received with no gap.
REQ-023 SHALL never assert frame_valid for a partial frame.

Reset
REQ-024 SHALL, while reset=1, immediately force state IDLE, bit counter 0, shift register 0, running parity 0, and outputs data_out=0, frame_valid=0, parity_err=0, frame_err=0, busy=0.
REQ-025 SHALL abandon a partially received frame on reset, with no frame_valid pulse afterwards.

Structure
REQ-026 SHALL take the state enum {IDLE, DATA, PARITY, STOP} and the frame-format constants (start value 0, stop value 1) from a shared package, paridade_pkg.
REQ-027 SHALL instantiate one sub-module, acumulador_paridade, as a 1-bit toggle register with synchronous clear and enable ports, plus async reset.

Verification
REQ-028 SHALL cover: DATA_BITS=8, even parity, bits 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0) -> frame_valid pulse, data_out=0xA5, parity_err=0, frame_err=0.
REQ-029 SHALL cover: the same frame with parity bit 1 -> data_out=0xA5, parity_err=1, frame_err=0.
REQ-030 SHALL cover: 0x3C with correct parity and stop bit 0 -> frame_err=1, parity_err=0, FSM in IDLE; a following valid 0x81 frame is received correctly.
REQ-031 SHALL cover: 0x5A frame with 0-3 cycles of in_valid=0 randomly inserted between bits -> same result as the gapless frame; exactly one frame_valid pulse.
REQ-032 SHALL cover: reset asserted after 4 data bits, then released, then a full 0xFF frame -> no pulse for the aborted frame; then data_out=0xFF, parity_err=0.
REQ-033 SHALL cover: ODD_PARITY=1, data 0x00 with parity bit 1, sent back-to-back twice -> two frame_valid pulses 11 valid cycles apart, parity_err=0.
